// File: rtl/conv_bin_pkg.sv
// rtl/conv_bin_pkg.sv - shared constants and helpers for the binary 3x3 conv stream
package conv_bin_pkg;

  localparam int KSIZE = 3;
  localparam int TAPS  = KSIZE * KSIZE;
  localparam int POP_W = 4;

  // Counter/index width for a range of n values; never narrower than one bit.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [POP_W-1:0] popcount9(input logic [TAPS-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < TAPS; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/conv_bin_linebuf.sv
// rtl/conv_bin_linebuf.sv - raster counters, SOF resync, two-row line buffer and 3x3 window
module conv_bin_linebuf
  import conv_bin_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_in,
  input  logic            pix_valid,
  input  logic            pix_sof,
  output logic [TAPS-1:0] win,
  output logic            win_valid,
  output logic            win_last
);

  localparam int COL_W = width_for(IMG_W);
  localparam int ROW_W = width_for(IMG_H);

  logic [COL_W-1:0] col, col_eff;
  logic [ROW_W-1:0] row, row_eff;
  logic [IMG_W-1:0] lb0, lb1;

  // A start-of-frame pixel is placed at (0,0) no matter where the counters are.
  always_comb begin
    col_eff = pix_sof ? '0 : col;
    row_eff = pix_sof ? '0 : row;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      lb0       <= '0;
      lb1       <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      if (pix_valid) begin
        if (col_eff == COL_W'(IMG_W - 1)) begin
          col <= '0;
          row <= (row_eff == ROW_W'(IMG_H - 1)) ? '0 : row_eff + 1'b1;
        end else begin
          col <= col_eff + 1'b1;
          row <= row_eff;
        end
        // Line-buffer taps IMG_W and 2*IMG_W acceptances back are the pixels above.
        lb0 <= {lb0[IMG_W-2:0], pix_in};
        lb1 <= {lb1[IMG_W-2:0], lb0[IMG_W-1]};
        win <= {pix_in, win[8:7], lb0[IMG_W-1], win[5:4], lb1[IMG_W-1], win[2:1]};
        win_valid <= (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));
        win_last  <= (row_eff == ROW_W'(IMG_H - 1)) && (col_eff == COL_W'(IMG_W - 1));
      end
    end
  end

endmodule

// File: rtl/conv_bin3x3_stream.sv
// rtl/conv_bin3x3_stream.sv - streaming binary 3x3 convolution with per-channel kernel and threshold
module conv_bin3x3_stream
  import conv_bin_pkg::*;
#(
  parameter int                     IMG_W    = 28,
  parameter int                     IMG_H    = 28,
  parameter int                     N_CH     = 8,
  parameter logic [N_CH*TAPS-1:0]   W_INIT   = '0,
  parameter logic [N_CH*POP_W-1:0]  THR_INIT = {N_CH{4'd5}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_in,
  input  logic                         pix_valid,
  input  logic                         pix_sof,
  input  logic                         cfg_we,
  input  logic [width_for(N_CH)-1:0]   cfg_ch,
  input  logic [TAPS-1:0]              cfg_w,
  input  logic [POP_W-1:0]             cfg_thr,
  output logic [N_CH-1:0]              conv_out,
  output logic                         out_valid,
  output logic                         out_last
);

  localparam int CH_W = width_for(N_CH);

  logic [TAPS-1:0]        win;
  logic                   win_valid, win_last;
  logic [N_CH*TAPS-1:0]   kern;
  logic [N_CH*POP_W-1:0]  thr;
  logic [POP_W-1:0]       pop [N_CH];
  logic                   pop_valid, pop_last;

  conv_bin_linebuf #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_linebuf (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .win       (win),
    .win_valid (win_valid),
    .win_last  (win_last)
  );

  // Channel indices with no matching register simply never hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      kern <= W_INIT;
      thr  <= THR_INIT;
    end else if (cfg_we) begin
      for (int c = 0; c < N_CH; c++) begin
        if (cfg_ch == CH_W'(c)) begin
          kern[c*TAPS +: TAPS]   <= cfg_w;
          thr[c*POP_W +: POP_W]  <= cfg_thr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_valid <= 1'b0;
      pop_last  <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        pop[c] <= '0;
      end
    end else begin
      pop_valid <= win_valid;
      pop_last  <= win_last;
      for (int c = 0; c < N_CH; c++) begin
        pop[c] <= popcount9(~(win ^ kern[c*TAPS +: TAPS]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_out  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= pop_valid;
      out_last  <= pop_valid & pop_last;
      if (pop_valid) begin
        for (int c = 0; c < N_CH; c++) begin
          conv_out[c] <= (pop[c] >= thr[c*POP_W +: POP_W]);
        end
      end
    end
  end

endmodule
